ysyx_22041071_mem_arb: RTL and testbench

YSYX_22041071_MEM_ARB -- requirements
Module: ysyx_22041071_mem_arb

---
 rtl/ysyx_22041071_mem_arb.sv | 144 ++++++++++++++
 tb/tb_ysyx_22041071_mem_arb.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_mem_arb.sv
// Arbiter sharing one single-port RAM between instruction fetch and load/store.
// One access in flight at a time: IDLE grant -> ACC -> WAIT (MEM_LAT cycles) -> RESP.
module ysyx_22041071_mem_arb #(
  parameter int          MEM_LAT    = 1,
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int          STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_resp_valid,
  input  logic        if_resp_ready,
  output logic [31:0] if_resp_data,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [63:0] mem_req_addr,
  input  logic        mem_req_wen,
  input  logic [63:0] mem_req_wdata,
  input  logic [63:0] mem_req_wmask,
  output logic        mem_resp_valid,
  input  logic        mem_resp_ready,
  output logic [63:0] mem_resp_data,
  output logic        ram_en,
  output logic [63:0] ram_idx,
  output logic        ram_wen,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  input  logic [63:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic        owner_reg;  // 1 = MEM port owns the access, 0 = IF port
  logic [63:0] addr_reg;
  logic        wen_reg;
  logic [63:0] wdata_reg;
  logic [63:0] wmask_reg;
  logic [7:0]  starve_reg;
  logic [2:0]  wait_reg;
  logic [63:0] resp_reg;
  logic [63:0] resp_next;
  logic        grant_if, grant_mem;
  logic        in_range, starved;

  assign in_range  = (addr_reg >= BASE);
  assign starved   = (starve_reg == 8'(STARVE_MAX));
  // Logical shift keeps the top three index bits zero.
  assign ram_idx   = (addr_reg - BASE) >> 3;
  assign ram_wdata = wdata_reg;

  assign if_resp_data  = resp_reg[31:0];
  assign mem_resp_data = resp_reg;

  always_comb begin
    if (!in_range)
      resp_next = 64'h0;
    else if (!owner_reg)
      resp_next = {32'h0, addr_reg[2] ? ram_rdata[63:32] : ram_rdata[31:0]};
    else if (wen_reg)
      resp_next = 64'h0;
    else
      resp_next = ram_rdata;
  end

  always_comb begin
    state_next     = state_reg;
    grant_if       = 1'b0;
    grant_mem      = 1'b0;
    if_req_ready   = 1'b0;
    mem_req_ready  = 1'b0;
    if_resp_valid  = 1'b0;
    mem_resp_valid = 1'b0;
    ram_en         = 1'b0;
    ram_wen        = 1'b0;
    ram_wmask      = 64'h0;
    case (state_reg)
      IDLE: begin
        if (!reset) begin
          grant_mem     = mem_req_valid && !(if_req_valid && starved);
          grant_if      = if_req_valid && !grant_mem;
          if_req_ready  = grant_if;
          mem_req_ready = grant_mem;
          if (grant_if || grant_mem)
            state_next = ACC;
        end
      end
      ACC: begin
        ram_en     = in_range;
        ram_wen    = in_range && wen_reg;
        ram_wmask  = in_range ? wmask_reg : 64'h0;
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_reg == 3'd1)
          state_next = RESP;
      end
      RESP: begin
        if_resp_valid  = !owner_reg;
        mem_resp_valid = owner_reg;
        if (owner_reg ? mem_resp_ready : if_resp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b0;
      addr_reg   <= 64'h0;
      wen_reg    <= 1'b0;
      wdata_reg  <= 64'h0;
      wmask_reg  <= 64'h0;
      starve_reg <= 8'h0;
      wait_reg   <= 3'h0;
      resp_reg   <= 64'h0;
    end else begin
      state_reg <= state_next;
      if (grant_if || grant_mem) begin
        owner_reg <= grant_mem;
        addr_reg  <= grant_mem ? mem_req_addr : if_req_addr;
        wen_reg   <= grant_mem && mem_req_wen;
        wdata_reg <= grant_mem ? mem_req_wdata : 64'h0;
        wmask_reg <= grant_mem ? mem_req_wmask : 64'h0;
      end
      // Only MEM grants that bypass a waiting fetch count towards starvation.
      if (grant_mem && if_req_valid && !starved)
        starve_reg <= starve_reg + 8'd1;
      else if (grant_if)
        starve_reg <= 8'h0;
      if (state_reg == ACC)
        wait_reg <= 3'(MEM_LAT);
      else if (state_reg == WAIT)
        wait_reg <= wait_reg - 3'd1;
      if (state_reg == WAIT && wait_reg == 3'd1)
        resp_reg <= resp_next;
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_mem_arb.sv
// Scenario bench for the IF/MEM RAM arbiter with a 1-cycle RAM model and
// a response scoreboard fed by the request drivers.
module tb_ysyx_22041071_mem_arb;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [63:0] if_req_addr = 64'h0;
  logic        if_resp_valid, if_resp_ready = 1'b1;
  logic [31:0] if_resp_data;
  logic        mem_req_valid = 1'b0, mem_req_ready;
  logic [63:0] mem_req_addr = 64'h0;
  logic        mem_req_wen = 1'b0;
  logic [63:0] mem_req_wdata = 64'h0, mem_req_wmask = 64'h0;
  logic        mem_resp_valid, mem_resp_ready = 1'b1;
  logic [63:0] mem_resp_data;
  logic        ram_en, ram_wen;
  logic [63:0] ram_idx, ram_wdata, ram_wmask;
  logic [63:0] ram_rdata = 64'h0;

  logic        ram_init = 1'b1;
  logic [63:0] ram    [16];
  logic [63:0] sh_mem [16];
  logic [63:0] exp_if_q[$];
  logic [63:0] exp_mem_q[$];
  int          grant_log[$];
  int          cyc = 0, en_cnt = 0;
  int          last_if_acc = 0, last_mem_acc = 0;
  int          checks = 0, errors = 0;

  ysyx_22041071_mem_arb dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_data(if_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data),
    .ram_en(ram_en), .ram_idx(ram_idx), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int i);
    if (i == 0) return 64'hAAAA_BBBB_1111_2222;
    return {32'hC0DE_0000 | 32'(i), 32'h1234_0000 | 32'(i)};
  endfunction

  function automatic logic [63:0] exp_read(input logic [63:0] a, input logic is_if);
    logic [63:0] w;
    if (a < BASE) return 64'h0;
    w = sh_mem[4'((a - BASE) >> 3)];
    if (is_if) return {32'h0, a[2] ? w[63:32] : w[31:0]};
    return w;
  endfunction

  // RAM model: one cycle from the enable edge to valid read data.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
    end else if (ram_en) begin
      if (ram_wen)
        ram[ram_idx[3:0]] <= (ram[ram_idx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
      ram_rdata <= ram[ram_idx[3:0]];
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor: pops the scoreboard on every response handshake.
  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (!reset) begin
      if (ram_en) en_cnt++;
      if (if_resp_valid && if_resp_ready) begin
        checks++;
        if (exp_if_q.size() == 0) begin
          errors++;
          $display("FAIL if_resp_unexpected got=%h", if_resp_data);
        end else begin
          e = exp_if_q.pop_front();
          if (if_resp_data !== e[31:0]) begin
            errors++;
            $display("FAIL if_resp_data got=%h exp=%h", if_resp_data, e[31:0]);
          end else
            $display("cyc %0d if_resp data=%h", cyc, if_resp_data);
        end
      end
      if (mem_resp_valid && mem_resp_ready) begin
        checks++;
        if (exp_mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_resp_unexpected got=%h", mem_resp_data);
        end else begin
          e = exp_mem_q.pop_front();
          if (mem_resp_data !== e) begin
            errors++;
            $display("FAIL mem_resp_data got=%h exp=%h", mem_resp_data, e);
          end else
            $display("cyc %0d mem_resp data=%h", cyc, mem_resp_data);
        end
      end
    end
  end

  task automatic do_if(input logic [63:0] a);
    int n = 0;
    if_req_addr  = a;
    if_req_valid = 1'b1;
    #1;
    while (!if_req_ready && n < 200) begin
      @(posedge clk); #2; n++;
    end
    checks++;
    if (!if_req_ready) begin
      errors++;
      $display("FAIL if_grant_timeout addr=%h waited=%0d", a, n);
    end else begin
      exp_if_q.push_back(exp_read(a, 1'b1));
      grant_log.push_back(0);
      last_if_acc = cyc;
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
  endtask

  task automatic do_mem(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [63:0] m);
    int n = 0;
    mem_req_addr  = a;
    mem_req_wen   = w;
    mem_req_wdata = d;
    mem_req_wmask = m;
    mem_req_valid = 1'b1;
    #1;
    while (!mem_req_ready && n < 200) begin
      @(posedge clk); #2; n++;
    end
    checks++;
    if (!mem_req_ready) begin
      errors++;
      $display("FAIL mem_grant_timeout addr=%h waited=%0d", a, n);
    end else begin
      if (w) begin
        exp_mem_q.push_back(64'h0);
        if (a >= BASE)
          sh_mem[4'((a - BASE) >> 3)] = (sh_mem[4'((a - BASE) >> 3)] & ~m) | (d & m);
      end else
        exp_mem_q.push_back(exp_read(a, 1'b0));
      grant_log.push_back(1);
      last_mem_acc = cyc;
    end
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    mem_req_wen   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_if_q.size() != 0 || exp_mem_q.size() != 0) && n < 100) begin
      @(posedge clk); #2; n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL drain_timeout if_left=%0d mem_left=%0d", exp_if_q.size(), exp_mem_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) sh_mem[i] = init_word(i);
    if_req_valid  = 1'b1;
    mem_req_valid = 1'b1;
    mem_req_addr  = BASE;
    if_req_addr   = BASE;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({if_req_ready, mem_req_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_req_ready got=%b exp=00", {if_req_ready, mem_req_ready});
    end
    checks++;
    if ({if_resp_valid, mem_resp_valid, ram_en, ram_wen} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0000", {if_resp_valid, mem_resp_valid, ram_en, ram_wen});
    end
    checks++;
    if (ram_wmask !== 64'h0 || mem_resp_data !== 64'h0 || if_resp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data wmask=%h mem=%h if=%h exp=0", ram_wmask, mem_resp_data, if_resp_data);
    end
    if_req_valid  = 1'b0;
    mem_req_valid = 1'b0;
    ram_init      = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("cyc %0d reset released", cyc);
  endtask

  task automatic test_if_fetch();
    @(posedge clk); #1;
    if_req_addr  = 64'h8000_0004;
    if_req_valid = 1'b1;
    #1;
    checks++;
    if ({if_req_ready, mem_req_ready} !== 2'b10) begin
      errors++;
      $display("FAIL fetch_grant got=%b exp=10", {if_req_ready, mem_req_ready});
    end
    exp_if_q.push_back(64'hAAAA_BBBB);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    #1;
    checks++;
    if (ram_en !== 1'b1 || ram_idx !== 64'h0 || ram_wen !== 1'b0 || if_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_acc en=%b idx=%h wen=%b rdy=%b exp en=1 idx=0 wen=0 rdy=0",
               ram_en, ram_idx, ram_wen, if_req_ready);
    end
    @(posedge clk); #2;
    checks++;
    if (ram_en !== 1'b0 || if_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait en=%b resp_valid=%b exp 0 0", ram_en, if_resp_valid);
    end
    @(posedge clk); #2;
    checks++;
    if (if_resp_valid !== 1'b1 || mem_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_latency if_valid=%b mem_valid=%b exp 1 0", if_resp_valid, mem_resp_valid);
    end
    @(posedge clk); #2;
    checks++;
    if (if_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done if_valid=%b exp=0", if_resp_valid);
    end
    #9;
  endtask

  task automatic test_arb();
    grant_log.delete();
    @(posedge clk); #1;
    fork
      do_mem(64'h8000_0008, 1'b0, 64'h0, 64'h0);
      do_if(64'h8000_0018);
    join
    wait_idle();
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 0) begin
      errors++;
      $display("FAIL arb_order size=%0d exp order MEM,IF", grant_log.size());
    end
    checks++;
    if (last_if_acc - last_mem_acc != 4) begin
      errors++;
      $display("FAIL arb_if_gap got=%0d exp=4", last_if_acc - last_mem_acc);
    end
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    fork
      do_mem(64'h8000_0010, 1'b1, 64'h5500, 64'h0000_0000_0000_ff00);
      begin
        int n = 0;
        do begin
          @(posedge clk); #2; n++;
        end while (!ram_en && n < 20);
        checks++;
        if (ram_wen !== 1'b1 || ram_idx !== 64'd2 || ram_wmask !== 64'hff00 || ram_wdata !== 64'h5500) begin
          errors++;
          $display("FAIL store_acc wen=%b idx=%h wmask=%h wdata=%h exp 1 2 ff00 5500",
                   ram_wen, ram_idx, ram_wmask, ram_wdata);
        end
        @(posedge clk); #2;
        checks++;
        if (ram_en !== 1'b0 || ram_wen !== 1'b0 || ram_wmask !== 64'h0) begin
          errors++;
          $display("FAIL store_one_cycle en=%b wen=%b wmask=%h exp 0", ram_en, ram_wen, ram_wmask);
        end
      end
    join
    wait_idle();
    do_mem(64'h8000_0010, 1'b0, 64'h0, 64'h0);
    wait_idle();
  endtask

  task automatic test_out_of_range();
    int e;
    e = en_cnt;
    do_if(64'h0000_1004);
    wait_idle();
    do_mem(64'h7FFF_FFF8, 1'b0, 64'h0, 64'h0);
    wait_idle();
    checks++;
    if (en_cnt != e) begin
      errors++;
      $display("FAIL oor_ram_en got=%0d exp=0 enable cycles", en_cnt - e);
    end
  endtask

  task automatic test_backpressure();
    mem_resp_ready = 1'b0;
    do_mem(64'h8000_0020, 1'b0, 64'h0, 64'h0);
    fork
      do_if(64'h8000_0000);
      begin
        int n = 0;
        logic [63:0] exp;
        exp = exp_mem_q[0];
        while (!mem_resp_valid && n < 20) begin
          @(posedge clk); #2; n++;
        end
        for (int k = 0; k < 5; k++) begin
          checks++;
          if (mem_resp_valid !== 1'b1 || mem_resp_data !== exp || if_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold k=%0d valid=%b data=%h rdy=%b exp 1 %h 0",
                     k, mem_resp_valid, mem_resp_data, if_req_ready, exp);
          end
          @(posedge clk); #2;
        end
        mem_resp_ready = 1'b1;
      end
    join
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int t0;
    do_mem(64'h8000_0038, 1'b0, 64'h0, 64'h0);
    t0 = last_mem_acc;
    do_mem(64'h8000_0040, 1'b0, 64'h0, 64'h0);
    checks++;
    if (last_mem_acc - t0 != 4) begin
      errors++;
      $display("FAIL back_to_back_gap got=%0d exp=4", last_mem_acc - t0);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_wait();
    int rel;
    @(posedge clk); #1;
    mem_req_addr  = 64'h8000_0008;
    mem_req_wen   = 1'b0;
    mem_req_valid = 1'b1;
    #1;
    checks++;
    if (mem_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_grant got=%b exp=1", mem_req_ready);
    end
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_resp_valid, if_resp_valid, mem_req_ready, ram_en} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_in_reset got=%b exp=0000",
               {mem_resp_valid, if_resp_valid, mem_req_ready, ram_en});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rel = cyc;
    do_if(64'h8000_000C);
    checks++;
    if (last_if_acc != rel) begin
      errors++;
      $display("FAIL first_grant_after_reset got=%0d exp=%0d", last_if_acc, rel);
    end
    wait_idle();
  endtask

  task automatic test_starve();
    int exp_order[12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
    grant_log.delete();
    @(posedge clk); #1;
    fork
      begin
        do_if(64'h8000_0028);
        do_if(64'h8000_0030);
      end
      begin
        for (int k = 0; k < 10; k++) do_mem(64'h8000_0048, 1'b0, 64'h0, 64'h0);
      end
    join
    wait_idle();
    checks++;
    if (grant_log.size() != 12) begin
      errors++;
      $display("FAIL starve_count got=%0d exp=12 grants", grant_log.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (grant_log[k] != exp_order[k]) begin
          errors++;
          $display("FAIL starve_order k=%0d got=%0d exp=%0d", k, grant_log[k], exp_order[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_arb();
    test_store();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    test_starve();
    checks++;
    if (exp_if_q.size() != 0 || exp_mem_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left if=%0d mem=%0d exp 0", exp_if_q.size(), exp_mem_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
